mcb_port_responder: RTL and testbench

//  Synthesizable BRAM-backed responder for one MCB-style user port (p0_*), the memory side of the

---
 rtl/mcb_port_responder_pkg.sv | 39 +++
 rtl/mcb_sync_fifo.sv | 65 ++++++
 rtl/mcb_port_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_mcb_port_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_port_responder_pkg.sv
// Shared definitions for the MCB port responder: command encodings,
// sticky error bit positions, executor states and the command word layout.
package mcb_port_responder_pkg;

    localparam logic [2:0] INSTR_WR    = 3'b000;
    localparam logic [2:0] INSTR_RD    = 3'b001;
    localparam logic [2:0] INSTR_WR_AP = 3'b010;
    localparam logic [2:0] INSTR_RD_AP = 3'b011;

    localparam int ERR_CMD_OVF = 0;
    localparam int ERR_WR_OVF  = 1;
    localparam int ERR_RD_UNF  = 2;

    typedef enum logic [2:0] {
        S_CALIB = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]  instr;
        logic [29:0] addr;
        logic [5:0]  bl;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Auto-precharge variants behave exactly like the plain commands here.
    function automatic logic instr_is_wr(input logic [2:0] instr);
        return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
    endfunction

    function automatic logic instr_is_rd(input logic [2:0] instr);
        return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
    endfunction

endpackage

// File: rtl/mcb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head word is presented combinationally while not empty and reads as
// zero when empty. A pop on a full FIFO frees room for a same-cycle push.
module mcb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_count = r_count;
    assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

    assign w_pop  = i_rd_en && !o_empty;
    assign w_push = i_wr_en && (!o_full || w_pop);

    // Storage array; contents are data and are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mcb_port_responder.sv
// BRAM-backed responder for one MCB-style user port (p0_*).
// Commands, write data and read data are buffered in FWFT FIFOs; an in-order
// executor moves bursts between the FIFOs and an inferred 32-bit RAM.
// Optional feature: define MCB_RESP_BYTE_MASK_EN to make p0_wr_mask gate the
// RAM byte enables; otherwise the mask is carried but every write is full-word.
module mcb_port_responder
    import mcb_port_responder_pkg::*;
#(
    parameter int MEM_AW       = 12,
    parameter int CMD_DEPTH    = 4,
    parameter int DATA_DEPTH   = 64,
    parameter int CALIB_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        calib_done,
    input  logic        p0_cmd_en,
    input  logic [2:0]  p0_cmd_instr,
    input  logic [29:0] p0_cmd_byte_addr,
    input  logic [5:0]  p0_cmd_bl,
    output logic        p0_cmd_full,
    output logic        p0_cmd_empty,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_wr_data,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_wr_full,
    output logic        p0_wr_empty,
    output logic [6:0]  p0_wr_count,
    input  logic        p0_rd_en,
    output logic [31:0] p0_rd_data,
    output logic        p0_rd_full,
    output logic        p0_rd_empty,
    output logic [6:0]  p0_rd_count,
    output logic [2:0]  err
);

    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam int CCW   = $clog2(CMD_DEPTH) + 1;
    localparam int DCW   = $clog2(DATA_DEPTH) + 1;
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);

    // Control state
    logic              r_calib_done;
    logic [CAL_W-1:0]  r_cal_cnt;
    state_t            r_state;
    logic              r_rd_vld;
    logic [2:0]        r_err;

    // Burst datapath state
    logic [MEM_AW-1:0] r_addr;
    logic [5:0]        r_remain;
    logic [31:0]       r_ram_q;
    logic [31:0]       r_ram [2**MEM_AW];

    // FIFO interconnect
    cmd_t              w_cmd_in;
    cmd_t              w_cmd_head;
    logic [CMD_W-1:0]  w_cmd_dout;
    logic              w_cmd_full;
    logic              w_cmd_empty;
    logic [CCW-1:0]    w_cmd_count;
    logic              w_cmd_pop;
    logic [35:0]       w_wr_head;
    logic              w_wr_full;
    logic [DCW-1:0]    w_wr_count;
    logic              w_wr_pop;
    logic              w_wr_ready;
    logic              w_rd_empty;
    logic [DCW-1:0]    w_rd_count;
    logic              w_rd_space;
    logic              w_rd_issue;
    logic              w_unused;

    assign w_cmd_in   = '{instr: p0_cmd_instr, addr: p0_cmd_byte_addr, bl: p0_cmd_bl};
    assign w_cmd_head = cmd_t'(w_cmd_dout);

    // Burst may start (and then keeps running) once the whole remainder is available.
    assign w_wr_ready = int'(w_wr_count) >= int'(r_remain) + 1;
    assign w_rd_space = int'(w_rd_count) + int'(r_remain) + 1 <= DATA_DEPTH;

    assign w_cmd_pop  = (r_state == S_IDLE) && !w_cmd_empty;
    assign w_wr_pop   = (r_state == S_WRITE) && w_wr_ready && !reset;
    assign w_rd_issue = (r_state == S_READ) && w_rd_space && !reset;

    assign calib_done   = r_calib_done;
    assign p0_cmd_full  = w_cmd_full || !r_calib_done;
    assign p0_cmd_empty = w_cmd_empty;
    assign p0_wr_full   = w_wr_full || !r_calib_done;
    assign p0_wr_count  = 7'(w_wr_count);
    assign p0_rd_empty  = w_rd_empty;
    assign p0_rd_count  = 7'(w_rd_count);
    assign err          = r_err;

    assign w_unused = ^{w_cmd_count, w_cmd_head.addr, w_wr_head[35:32]};

    mcb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr_en (p0_cmd_en && r_calib_done),
        .i_din   (w_cmd_in),
        .i_rd_en (w_cmd_pop),
        .o_dout  (w_cmd_dout),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    mcb_sync_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr_en (p0_wr_en && r_calib_done),
        .i_din   ({p0_wr_mask, p0_wr_data}),
        .i_rd_en (w_wr_pop),
        .o_dout  (w_wr_head),
        .o_full  (w_wr_full),
        .o_empty (p0_wr_empty),
        .o_count (w_wr_count)
    );

    mcb_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr_en (r_rd_vld),
        .i_din   (r_ram_q),
        .i_rd_en (p0_rd_en),
        .o_dout  (p0_rd_data),
        .o_full  (p0_rd_full),
        .o_empty (w_rd_empty),
        .o_count (w_rd_count)
    );

    // Calibration delay: count cycles with reset low, then hold calib_done high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cal_cnt    <= '0;
            r_calib_done <= 1'b0;
        end else if (!r_calib_done) begin
            r_cal_cnt <= r_cal_cnt + 1'b1;
            if (r_cal_cnt == CAL_LAST) begin
                r_calib_done <= 1'b1;
            end
        end
    end

    // Sticky error flags for dropped pushes and empty pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (p0_cmd_en && (!r_calib_done || (w_cmd_full && !w_cmd_pop))) begin
                r_err[ERR_CMD_OVF] <= 1'b1;
            end
            if (p0_wr_en && (!r_calib_done || (w_wr_full && !w_wr_pop))) begin
                r_err[ERR_WR_OVF] <= 1'b1;
            end
            if (p0_rd_en && w_rd_empty) begin
                r_err[ERR_RD_UNF] <= 1'b1;
            end
        end
    end

    // In-order command executor; burst address/length are data and not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_CALIB;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_issue;
            case (r_state)
                S_CALIB: begin
                    if (r_calib_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!w_cmd_empty) begin
                        r_addr   <= w_cmd_head.addr[MEM_AW+1:2];
                        r_remain <= w_cmd_head.bl;
                        if (instr_is_wr(w_cmd_head.instr)) begin
                            r_state <= S_WRITE;
                        end else if (instr_is_rd(w_cmd_head.instr)) begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wr_pop) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_remain == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_remain == '0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_CALIB;
                end
            endcase
        end
    end

    // Backing RAM: write port fed from the write FIFO, registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_pop) begin
`ifdef MCB_RESP_BYTE_MASK_EN
            for (int b = 0; b < 4; b++) begin
                if (!w_wr_head[32+b]) begin
                    r_ram[r_addr][8*b +: 8] <= w_wr_head[8*b +: 8];
                end
            end
`else
            r_ram[r_addr] <= w_wr_head[31:0];
`endif
        end
        if (w_rd_issue) begin
            r_ram_q <= r_ram[r_addr];
        end
    end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Scoreboard bench for mcb_port_responder: stimulus pushes expected read words
// into a queue, a monitor pops the read FIFO and compares against the queue.
module tb_mcb_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [29:0] p0_cmd_byte_addr;
    logic [5:0]  p0_cmd_bl;
    logic        p0_cmd_full;
    logic        p0_cmd_empty;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic        p0_wr_empty;
    logic [6:0]  p0_wr_count;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_full;
    logic        p0_rd_empty;
    logic [6:0]  p0_rd_count;
    logic [2:0]  err;

    logic        mon_rd_en;
    logic        stim_rd_en;
    int          checks = 0;
    int          failures = 0;
    int          drain_left = 0;
    logic [31:0] exp_q[$];

    assign p0_rd_en = mon_rd_en | stim_rd_en;

    always #5 clk = ~clk;

    mcb_port_responder dut (
        .clk              (clk),
        .reset            (reset),
        .calib_done       (calib_done),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_bl        (p0_cmd_bl),
        .p0_cmd_full      (p0_cmd_full),
        .p0_cmd_empty     (p0_cmd_empty),
        .p0_wr_en         (p0_wr_en),
        .p0_wr_data       (p0_wr_data),
        .p0_wr_mask       (p0_wr_mask),
        .p0_wr_full       (p0_wr_full),
        .p0_wr_empty      (p0_wr_empty),
        .p0_wr_count      (p0_wr_count),
        .p0_rd_en         (p0_rd_en),
        .p0_rd_data       (p0_rd_data),
        .p0_rd_full       (p0_rd_full),
        .p0_rd_empty      (p0_rd_empty),
        .p0_rd_count      (p0_rd_count),
        .err              (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
        p0_wr_en   = 1'b1;
        p0_wr_data = data;
        p0_wr_mask = mask;
        tick();
        p0_wr_en   = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [29:0] addr, input logic [5:0] bl);
        p0_cmd_en        = 1'b1;
        p0_cmd_instr     = instr;
        p0_cmd_byte_addr = addr;
        p0_cmd_bl        = bl;
        tick();
        p0_cmd_en        = 1'b0;
    endtask

    task automatic wait_rd_count(input int n, input int budget, input string name);
        int k = 0;
        while (p0_rd_count != 7'(n) && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(p0_rd_count), n);
    endtask

    task automatic wait_drained(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        int k = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        while (!calib_done && k < 100) begin
            tick();
            k++;
        end
        check("reset_calib_done", 32'(calib_done), 1);
        check("reset_err_clear", 32'(err), 0);
    endtask

    // Monitor: pops the read FIFO while the stimulus allows and scores each word.
    initial begin
        logic [31:0] exp;
        mon_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            if (drain_left > 0 && !p0_rd_empty) begin
                mon_rd_en = 1'b1;
                drain_left--;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected actual=%0h required=none", p0_rd_data);
                end else begin
                    exp = exp_q.pop_front();
                    check("rd_data", p0_rd_data, exp);
                end
            end else begin
                mon_rd_en = 1'b0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int first;
        int k;
        reset            = 1'b1;
        p0_cmd_en        = 1'b0;
        p0_cmd_instr     = 3'b000;
        p0_cmd_byte_addr = '0;
        p0_cmd_bl        = '0;
        p0_wr_en         = 1'b0;
        p0_wr_data       = '0;
        p0_wr_mask       = '0;
        stim_rd_en       = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        check("rst_calib_done", 32'(calib_done), 0);
        check("rst_cmd_empty", 32'(p0_cmd_empty), 1);
        check("rst_wr_empty", 32'(p0_wr_empty), 1);
        check("rst_rd_empty", 32'(p0_rd_empty), 1);
        check("rst_rd_full", 32'(p0_rd_full), 0);
        check("rst_wr_count", 32'(p0_wr_count), 0);
        check("rst_rd_count", 32'(p0_rd_count), 0);
        check("rst_rd_data", p0_rd_data, 0);
        check("rst_err", 32'(err), 0);

        // Calibration delay and pre-calibration command drop
        reset = 1'b0;
        first = -1;
        for (int c = 0; c < 80; c++) begin
            if (calib_done && first < 0) first = c;
            p0_cmd_en = (c == 10);
            if (c == 10) check("precal_cmd_full", 32'(p0_cmd_full), 1);
            tick();
        end
        p0_cmd_en = 1'b0;
        check("calib_rise_cycle", first, 64);
        check("precal_err", 32'(err), 32'b001);
        check("precal_cmd_empty", 32'(p0_cmd_empty), 1);

        do_reset();

        // 32-word write then read of address 0
        for (int i = 0; i < 32; i++) push_wr(i, 4'b0000);
        push_cmd(3'b000, 30'h0, 6'd31);
        push_cmd(3'b001, 30'h0, 6'd31);
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        wait_rd_count(32, 300, "t2_rd_count32");
        drain_left = 1000;
        wait_drained(200, "t2_drained");
        check("t2_err", 32'(err), 0);

        // Wrapping burst at the top of RAM
        for (int i = 0; i < 4; i++) push_wr(32'hA000_0000 + i, 4'b0000);
        push_cmd(3'b010, 30'h3FF8, 6'd3);
        push_cmd(3'b011, 30'h3FF8, 6'd3);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + i);
        push_cmd(3'b001, 30'h0, 6'd1);
        exp_q.push_back(32'hA000_0002);
        exp_q.push_back(32'hA000_0003);
        wait_drained(200, "t3_drained");

        // Read back-pressure: 40 words held, 32-word read waits for space
        drain_left = 0;
        push_cmd(3'b001, 30'h0, 6'd31);
        push_cmd(3'b001, 30'h0, 6'd7);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < (r == 0 ? 32 : 8); i++) begin
                if (i == 0)      exp_q.push_back(32'hA000_0002);
                else if (i == 1) exp_q.push_back(32'hA000_0003);
                else             exp_q.push_back(i);
            end
        end
        wait_rd_count(40, 300, "t4_rd_count40");
        push_cmd(3'b001, 30'h0, 6'd31);
        exp_q.push_back(32'hA000_0002);
        exp_q.push_back(32'hA000_0003);
        for (int i = 2; i < 32; i++) exp_q.push_back(i);
        for (int i = 0; i < 20; i++) tick();
        check("t4_rd_count_held", 32'(p0_rd_count), 40);
        drain_left = 8;
        k = 0;
        while (drain_left != 0 && k < 100) begin
            tick();
            k++;
        end
        wait_rd_count(64, 200, "t4_rd_count64");
        check("t4_rd_full", 32'(p0_rd_full), 1);
        drain_left = 1000;
        wait_drained(300, "t4_drained");
        check("t4_err", 32'(err), 0);

        // Write stall, command overflow and read underflow
        for (int i = 0; i < 10; i++) push_wr(32'h5000 + i, 4'b0000);
        push_cmd(3'b000, 30'h400, 6'd31);
        for (int i = 0; i < 10; i++) tick();
        check("t5_wr_count_stalled", 32'(p0_wr_count), 10);
        for (int i = 0; i < 5; i++) push_cmd(3'b100, 30'h0, 6'd0);
        check("t5_cmd_full", 32'(p0_cmd_full), 1);
        check("t5_err_cmd_ovf", 32'(err), 32'b001);
        stim_rd_en = 1'b1;
        tick();
        stim_rd_en = 1'b0;
        check("t5_err_rd_unf", 32'(err), 32'b101);
        for (int i = 10; i < 32; i++) push_wr(32'h5000 + i, 4'b0000);
        k = 0;
        while (!p0_wr_empty && k < 100) begin
            tick();
            k++;
        end
        check("t5_wr_count_done", 32'(p0_wr_count), 0);
        push_cmd(3'b001, 30'h400, 6'd31);
        for (int i = 0; i < 32; i++) exp_q.push_back(32'h5000 + i);
        wait_drained(300, "t5_drained");

        // Byte mask behaviour
        push_wr(32'hFFFF_FFFF, 4'b0000);
        push_cmd(3'b000, 30'h800, 6'd0);
        push_wr(32'h0000_0000, 4'b0101);
        push_cmd(3'b000, 30'h800, 6'd0);
        push_cmd(3'b001, 30'h800, 6'd0);
`ifdef MCB_RESP_BYTE_MASK_EN
        exp_q.push_back(32'h00FF_00FF);
`else
        exp_q.push_back(32'h0000_0000);
`endif
        wait_drained(100, "t6_drained");

        // Write FIFO fill to depth and overflow
        for (int i = 0; i < 64; i++) push_wr(i, 4'b0000);
        check("wr_count64", 32'(p0_wr_count), 64);
        check("wr_full", 32'(p0_wr_full), 1);
        push_wr(32'hDEAD_BEEF, 4'b0000);
        check("wr_count_after_ovf", 32'(p0_wr_count), 64);
        check("err_wr_ovf", 32'(err), 32'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
